// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_pkg
// Description : Shared definitions for the bit-serial CRC-8 engine.
//               - FSM state encoding (IDLE / SHIFT / DONE)
//               - Default polynomial, init value and output XOR constant
//               - Last bit index of a byte (the eighth shift)
//               - xor_gate: the 1-bit XOR primitive used for LFSR feedback
// Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

  // Encoding is fixed so that state values seen in waveforms stay meaningful.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } crc_state_t;

  // The x^8 term of the generator is implicit.
  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;
  localparam logic [7:0] CRC8_XOROUT       = 8'hFF;

  // Counter value during the eighth and final shift of a byte.
  localparam logic [2:0] CRC8_BIT_LAST     = 3'd7;

  // Single-bit XOR, the same semantics as the upstream xor_gate stage.
  function automatic logic xor_gate(input logic a, input logic b);
    return a ^ b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc8_step.sv
`default_nettype none
// ============================================================================
// Module      : crc8_step
// Description : Combinational single-bit CRC-8 LFSR update. The incoming
//               data bit is XORed with the register MSB to form the feedback
//               term; when feedback is set the polynomial is folded into the
//               left-shifted register.
// Ports       : crc       in  8  current CRC register
//               data_bit  in  1  next message bit (MSB-first stream)
//               crc_next  out 8  CRC register after absorbing data_bit
// Revision    : 1.0 - initial release
// ============================================================================
module crc8_step
  import crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT
) (
  input  logic [7:0] crc,
  input  logic       data_bit,
  output logic [7:0] crc_next
);

  logic w_fb;

  assign w_fb     = xor_gate(crc[7], data_bit);
  assign crc_next = {crc[6:0], 1'b0} ^ (w_fb ? POLY : 8'h00);

endmodule
`default_nettype wire

// File: rtl/crc8_serial.sv
`default_nettype none
// ============================================================================
// Module      : crc8_serial
// Description : Bit-serial CRC-8 engine. Bytes arrive on a valid/ready
//               port and are shifted MSB-first through the LFSR, one bit per
//               clock (8 shift cycles per byte). The CRC register carries
//               across bytes of a frame; when the byte flagged in_last has
//               been absorbed the result is presented on the crc_valid /
//               crc_ready port and held until taken.
// Build option: CRC8_FINAL_XOR_EN - when defined, crc_out is the register
//               XORed with 8'hFF; otherwise the raw register is presented.
// Ports       : clk        in  1  clock, rising edge
//               rst        in  1  synchronous active-high reset
//               in_valid   in  1  input byte valid
//               in_ready   out 1  engine can accept a byte (IDLE)
//               in_data    in  8  input byte, MSB processed first
//               in_last    in  1  final byte of the frame
//               crc_valid  out 1  crc_out holds a finished frame CRC
//               crc_ready  in  1  consumer accepts crc_out
//               crc_out    out 8  frame CRC
//               busy       out 1  high in SHIFT or DONE
// Revision    : 1.0 - initial release
// ============================================================================
module crc8_serial
  import crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       crc_valid,
  input  logic       crc_ready,
  output logic [7:0] crc_out,
  output logic       busy
);

  crc_state_t r_state;
  logic [7:0] r_crc;
  logic [7:0] r_sh;
  logic [2:0] r_cnt;
  logic       r_last;
  logic       r_in_ready;
  logic       r_crc_valid;
  logic [7:0] r_crc_out;
  logic       r_busy;

  logic [7:0] w_crc_next;
  logic [7:0] w_crc_final;

  crc8_step #(
    .POLY (POLY)
  ) u_step (
    .crc      (r_crc),
    .data_bit (r_sh[7]),
    .crc_next (w_crc_next)
  );

  // The result is captured on the last shift edge, so it is formed from the
  // register value that this edge is about to store.
`ifdef CRC8_FINAL_XOR_EN
  assign w_crc_final = w_crc_next ^ CRC8_XOROUT;
`else
  assign w_crc_final = w_crc_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_crc       <= INIT;
      r_sh        <= 8'h00;
      r_cnt       <= 3'd0;
      r_last      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_crc_valid <= 1'b0;
      r_crc_out   <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is an accept.
          if (in_valid) begin
            r_sh       <= in_data;
            r_last     <= in_last;
            r_cnt      <= 3'd0;
            r_state    <= ST_SHIFT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        ST_SHIFT: begin
          r_crc <= w_crc_next;
          r_sh  <= {r_sh[6:0], 1'b0};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == CRC8_BIT_LAST) begin
            if (r_last) begin
              r_state     <= ST_DONE;
              r_crc_valid <= 1'b1;
              r_crc_out   <= w_crc_final;
            end else begin
              r_state    <= ST_IDLE;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          // crc_out is held untouched until the consumer takes it.
          if (crc_ready) begin
            r_crc       <= INIT;
            r_state     <= ST_IDLE;
            r_crc_valid <= 1'b0;
            r_crc_out   <= 8'h00;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_crc       <= INIT;
          r_in_ready  <= 1'b1;
          r_crc_valid <= 1'b0;
          r_crc_out   <= 8'h00;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign crc_valid = r_crc_valid;
  assign crc_out   = r_crc_out;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_crc8_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc8_serial
// Description : Self-checking bench for crc8_serial. Expected CRCs come from
//               a byte-wise reference CRC-8 computed over the frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc8_serial;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       crc_valid;
  logic       crc_ready;
  logic [7:0] crc_out;
  logic       busy;

  int n_tests;
  int n_fail;

  crc8_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .crc_valid (crc_valid),
    .crc_ready (crc_ready),
    .crc_out   (crc_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: classic byte-at-a-time CRC-8, poly 0x07, init 0x00.
  function automatic logic [7:0] model_crc(input logic [7:0] fr[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (fr[i]) begin
      c = c ^ fr[i];
      for (int k = 0; k < 8; k++)
        c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
`ifdef CRC8_FINAL_XOR_EN
    c = c ^ 8'hFF;
`endif
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte, wait for acceptance, then verify the 8-cycle shift
  // window while spraying ignored in_valid pulses with junk data.
  task automatic send_byte(input logic [7:0] d, input logic last, input string tag);
    int  guard;
    bit  early;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      check_eq({tag, "_ready_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    tick();  // accept edge
    early = 1'b0;
    for (int k = 1; k < 8; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      if (in_ready || crc_valid || !busy) early = 1'b1;
      tick();
    end
    if (in_ready || crc_valid || !busy) early = 1'b1;
    in_valid = 1'b0;
    check_eq({tag, "_shift_window"}, 32'(early), 0);
    tick();  // eighth shift edge
    check_eq({tag, "_ready_after8"}, 32'(in_ready), 32'(!last));
    check_eq({tag, "_valid_after8"}, 32'(crc_valid), 32'(last));
  endtask

  // Collect the CRC after 'hold' back-pressured cycles, checking stability
  // and that input bytes are refused while the result waits.
  task automatic take_crc(input logic [7:0] exp, input int hold, input string tag);
    logic [7:0] first;
    bit         moved;
    check_eq({tag, "_crc"}, 32'(crc_out), 32'(exp));
    first = crc_out;
    moved = 1'b0;
    for (int k = 0; k < hold; k++) begin
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      in_last   = 1'b1;
      crc_ready = 1'b0;
      tick();
      if (crc_out !== first || !crc_valid || in_ready) moved = 1'b1;
    end
    in_valid = 1'b0;
    if (hold > 0) check_eq({tag, "_hold_stable"}, 32'(moved), 0);
    crc_ready = 1'b1;
    tick();
    crc_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(crc_valid), 0);
    check_eq({tag, "_ready_back"}, 32'(in_ready), 1);
  endtask

  task automatic run_frame(input logic [7:0] fr[$], input int hold, input string tag);
    for (int i = 0; i < fr.size(); i++)
      send_byte(fr[i], (i == fr.size() - 1), tag);
    take_crc(model_crc(fr), hold, tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"},  32'(in_ready),  1);
    check_eq({tag, "_crc_valid"}, 32'(crc_valid), 0);
    check_eq({tag, "_crc_out"},   32'(crc_out),   0);
    check_eq({tag, "_busy"},      32'(busy),      0);
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] s[$];
    int         len;

    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    crc_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_vals("reset");

    // One-byte frame with a known answer.
    fr = '{8'h01};
    send_byte(8'h01, 1'b1, "one");
`ifdef CRC8_FINAL_XOR_EN
    check_eq("one_known", 32'(crc_out), 32'h F8);
`else
    check_eq("one_known", 32'(crc_out), 32'h07);
`endif
    take_crc(model_crc(fr), 0, "one");

    // Standard check string "123456789".
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < s.size(); i++)
      send_byte(s[i], (i == s.size() - 1), "check");
`ifdef CRC8_FINAL_XOR_EN
    check_eq("check_known", 32'(crc_out), 32'h0B);
`else
    check_eq("check_known", 32'(crc_out), 32'hF4);
`endif
    take_crc(model_crc(s), 0, "check");

    // Back-pressure in DONE, then a fresh frame must start from INIT.
    fr = '{8'hA5, 8'h3C};
    run_frame(fr, 5, "bp");
    fr = '{8'h01};
    run_frame(fr, 0, "after_bp");

    // Abort during the 4th shift cycle of the second byte.
    send_byte(8'hDE, 1'b0, "abort");
    in_valid = 1'b1;
    in_data  = 8'hAD;
    in_last  = 1'b1;
    tick();  // accept edge
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_reset_vals("abort_rst");
    rst = 1'b0;
    fr = '{8'h01};
    run_frame(fr, 0, "post_abort");

    // Random frames with random back-pressure.
    for (int f = 0; f < 20; f++) begin
      fr.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
      run_frame(fr, $urandom_range(0, 3), $sformatf("rnd%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
